// File: rtl/ntt_sram_rd_streamer.sv
// ============================================================================
// Module   : ntt_sram_rd_streamer
// Purpose  : Reads a burst of 2^len_log2 32-bit words from a single-port SRAM
//            and streams them out as 16-bit coefficients (low half first)
//            over a valid/ready handshake. A 2-entry word FIFO absorbs the
//            one-cycle SRAM read latency and downstream back-pressure.
// Ports    : clk_i, rst_i        - clock, asynchronous active-high reset
//            start_i             - launch a burst (accepted only when idle)
//            base_addr_i         - first SRAM word address
//            len_log2_i          - burst length = 2^len_log2_i words
//            busy_o, done_o      - burst in progress / one-cycle completion
//            sram_req_o, sram_we_o, sram_addr_o, sram_rdata_i - SRAM port
//            coeff_valid_o, coeff_ready_i, coeff_data_o, coeff_last_o
//                                - coefficient stream
// Config   : define NTT_SRAM_RD_BITREV_EN to walk the word addresses in
//            bit-reversed order over the low len_log2 bits of the offset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_sram_rd_streamer #(
  parameter int AddrWidth = 7,
  parameter int LenW      = $clog2(AddrWidth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [LenW-1:0]      len_log2_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  input  logic [31:0]          sram_rdata_i,
  output logic                 coeff_valid_o,
  input  logic                 coeff_ready_i,
  output logic [15:0]          coeff_data_o,
  output logic                 coeff_last_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [AddrWidth:0] c_one = {{AddrWidth{1'b0}}, 1'b1};

  state_t               r_state;
  logic [AddrWidth-1:0] r_base;
  logic [LenW-1:0]      r_len;
  logic [AddrWidth:0]   r_issued;      // words requested so far this burst
  logic                 r_outstanding; // a read was issued last cycle
  logic                 r_done;

  // Two-word FIFO
  logic [31:0]          r_mem [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;
  logic                 r_half;        // 0: head low half next, 1: high half

  logic [AddrWidth:0]   w_total;
  logic [AddrWidth:0]   w_issued_nxt;
  logic [1:0]           w_pending;
  logic                 w_req;
  logic [AddrWidth-1:0] w_offset;
  logic                 w_valid;
  logic                 w_hs;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_last;
  logic [31:0]          w_head;

  assign w_total      = c_one << r_len;
  assign w_issued_nxt = r_issued + c_one;

  // Words already buffered plus the one in flight; a new read is only
  // issued when the FIFO is guaranteed to have room for its data.
  assign w_pending = r_count + {1'b0, r_outstanding};
  assign w_req     = (r_state == S_RUN) && (r_issued != w_total) && (w_pending < 2'd2);

`ifdef NTT_SRAM_RD_BITREV_EN
  // Reverse the full offset, then shift down so only the low len bits are
  // reversed (upper bits of the count are zero while requests are issued).
  logic [AddrWidth-1:0] w_rev_full;
  logic [LenW-1:0]      w_shamt;

  always_comb begin
    w_rev_full = '0;
    for (int i = 0; i < AddrWidth; i++) begin
      w_rev_full[i] = r_issued[AddrWidth-1-i];
    end
  end

  assign w_shamt  = LenW'(AddrWidth) - r_len;
  assign w_offset = w_rev_full >> w_shamt;
`else
  assign w_offset = r_issued[AddrWidth-1:0];
`endif

  assign w_valid = (r_count != 2'd0);
  assign w_hs    = w_valid && coeff_ready_i;
  assign w_push  = r_outstanding;
  assign w_pop   = w_hs && r_half;
  assign w_head  = r_mem[r_rd_ptr];

  // In DRAIN every word has been requested, so a lone buffered word with
  // nothing in flight is the final one.
  assign w_last = w_valid && r_half && (r_state == S_DRAIN) &&
                  (r_count == 2'd1) && !r_outstanding;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_base        <= '0;
      r_len         <= '0;
      r_issued      <= '0;
      r_outstanding <= 1'b0;
      r_done        <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_half        <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_outstanding <= w_req;

      if (w_req) begin
        r_issued <= w_issued_nxt;
      end

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_base   <= base_addr_i;
            r_len    <= len_log2_i;
            r_issued <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_req && (w_issued_nxt == w_total)) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_hs && w_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_hs) begin
        r_half <= ~r_half;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Data storage needs no reset: contents are only observed while valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= sram_rdata_i;
    end
  end

  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = r_done;
  assign sram_req_o    = w_req;
  assign sram_we_o     = 1'b0;
  assign sram_addr_o   = r_base + w_offset;
  assign coeff_valid_o = w_valid;
  assign coeff_data_o  = w_valid ? (r_half ? w_head[31:16] : w_head[15:0]) : 16'h0000;
  assign coeff_last_o  = w_last;

endmodule

`default_nettype wire

// File: doc/ntt_sram_rd_streamer.md
NTT_SRAM_RD_STREAMER -- requirements
Module: ntt_sram_rd_streamer

Interface
REQ-001 SHALL have parameter AddrWidth, default 7, SRAM word-address width (128 x 32-bit words = 256 x 16-bit coefficients).
REQ-002 SHALL have parameter LenW, default $clog2(AddrWidth+1), width of len_log2_i.
REQ-003 clk_i  input  1  sole clock; all state on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 start_i  input  1  launch a burst; sampled only in IDLE.
REQ-006 base_addr_i  input  AddrWidth  first SRAM word address; latched on accepted start.
REQ-007 len_log2_i  input  LenW  burst length = 2^len_log2_i words, legal range 0..AddrWidth; latched on accepted start.
REQ-008 busy_o  output  1  high in RUN and DRAIN.
REQ-009 done_o  output  1  one-cycle completion pulse.
REQ-010 sram_req_o  output  1  SRAM read request.
REQ-011 sram_we_o  output  1  constant 0.
REQ-012 sram_addr_o  output  AddrWidth  SRAM read address.
REQ-013 sram_rdata_i  input  32  SRAM read data, valid exactly one cycle after sram_req_o.
REQ-014 coeff_valid_o / coeff_ready_i / coeff_data_o[15:0] / coeff_last_o  output/input/output/output  coefficient stream, valid/ready handshake.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DRAIN; start_i in IDLE SHALL latch its inputs, clear counters and move to RUN next cycle; start_i outside IDLE SHALL be ignored.
REQ-016 In RUN, sram_req_o SHALL be high iff issued-word count < 2^len and (FIFO occupancy + outstanding reads) < 2.
REQ-017 sram_addr_o SHALL equal (base + offset) mod 2^AddrWidth, wrapping silently; offset increments by 1 per issued request.
REQ-018 After the last request has been issued, the FSM SHALL go RUN->DRAIN; DRAIN->IDLE on the final coefficient handshake.
REQ-019 sram_rdata_i SHALL be written into a 2-entry 32-bit FIFO on the cycle after each request; the FIFO SHALL never overflow.
REQ-020 The FIFO head SHALL emit coeff_data_o = word[15:0] first, then word[31:16]; the word pops on the handshake (valid&ready) of its upper half.
REQ-021 coeff_valid_o SHALL be high iff the FIFO is non-empty; coeff_data_o and coeff_last_o SHALL stay stable while valid&!ready.
REQ-022 coeff_last_o SHALL be high only on the upper half of the final word.
REQ-023 Minimum latency: start_i accepted at edge 0 -> sram_req_o high in cycle 1 -> coeff_valid_o high in cycle 3.
REQ-024 With coeff_ready_i held high, the block SHALL sustain 1 coefficient per cycle (one read every 2 cycles).
REQ-025 done_o SHALL pulse in the cycle after the final handshake, coincident with busy_o low; start_i in that cycle SHALL be accepted.
REQ-026 Simultaneous FIFO push and pop SHALL leave occupancy unchanged.

Reset
REQ-027 rst_i SHALL immediately force IDLE, empty the FIFO, clear counters and outstanding-read tracking, and force busy_o, done_o, sram_req_o, coeff_valid_o and coeff_last_o to 0, sram_addr_o to 0 and coeff_data_o to 0.
REQ-028 Reset mid-burst SHALL discard in-flight SRAM data; the first cycle after release SHALL be IDLE.

Configuration
REQ-029 Macro NTT_SRAM_RD_BITREV_EN, when defined, SHALL replace the address offset with its bit-reversal over the low len_log2 bits (word order for NTT input permutation); coefficient order within a word is unchanged.
REQ-030 Without NTT_SRAM_RD_BITREV_EN, the offset SHALL be linear (0,1,2,...), and no bit-reversal logic SHALL be synthesized.

Verification
REQ-031 base=0x10, len_log2=2, words 0x0002_0001..0x0008_0007, ready=1 -> addrs 0x10..0x13, coeffs 1..8 on consecutive cycles, last on 8, done one cycle later.
REQ-032 base=0x7E, len_log2=2 -> addrs 0x7E,0x7F,0x00,0x01 (wrap).
REQ-033 len_log2=3, coeff_ready_i toggling 1-of-3 cycles -> no lost or duplicated coefficient, sram_req_o never leaves >2 words pending.
REQ-034 NTT_SRAM_RD_BITREV_EN, base=0, len_log2=3 -> addr order 0,4,2,6,1,5,3,7.
REQ-035 rst_i asserted mid-DRAIN with valid&!ready -> all outputs 0 same cycle; a new start after release runs cleanly from base.
REQ-036 len_log2=0, start_i held high throughout -> single word, 2 coeffs, done pulse; restart accepted in done cycle.
